// File: rtl/btb_update_ctrl.sv
// BTB write scheduler: queues committed branch updates (coalescing repeats of the
// newest PC), drains one per cycle into the BTB, and sweeps every set on a flush.
module btb_update_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BTB_SETS   = 32,
    parameter int unsigned IDX_BITS   = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            upd_valid,
    output logic                            upd_ready,
    input  logic [31:0]                     upd_pc,
    input  logic [31:0]                     upd_target,
    input  logic                            upd_taken,
    input  logic                            upd_is_jal,
    input  logic                            flush_req,
    output logic                            flush_busy,
    output logic                            flush_done,
    input  logic                            btb_busy,
    output logic                            btb_wr_en,
    output logic [31:0]                     btb_wr_pc,
    output logic [31:0]                     btb_wr_target,
    output logic                            btb_wr_taken,
    output logic                            btb_wr_jal,
    output logic                            btb_inv_en,
    output logic [IDX_BITS-1:0]             btb_inv_idx,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

    state_t              state_q, state_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;

    logic [31:0] pc_mem     [FIFO_DEPTH];
    logic [31:0] tgt_mem    [FIFO_DEPTH];
    logic        taken_mem  [FIFO_DEPTH];
    logic        jal_mem    [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_idx, wr_idx, last_idx;
    logic [PTR_W:0]   occ;
    logic empty, full, in_service, pop, one_left, coalesce_hit;
    logic accept, push, coalesce;

    assign rd_idx     = rd_ptr_q[PTR_W-1:0];
    assign wr_idx     = wr_ptr_q[PTR_W-1:0];
    assign last_idx   = wr_idx - 1'b1;
    assign occ        = wr_ptr_q - rd_ptr_q;
    assign empty      = (rd_ptr_q == wr_ptr_q);
    assign full       = (rd_idx == wr_idx) && (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
    assign in_service = (state_q == IDLE) || (state_q == DRAIN);
    assign pop        = (state_q == DRAIN) && !empty && !btb_busy && !flush_req;
    assign one_left   = (occ == (PTR_W+1)'(1));

    // A newest entry that is also leaving this cycle cannot absorb the update.
    assign coalesce_hit = !empty && (upd_pc == pc_mem[last_idx]) && !(pop && one_left);
    assign upd_ready    = in_service && !flush_req && (!full || coalesce_hit);
    assign accept       = upd_valid && upd_ready;
    assign push         = accept && !coalesce_hit;
    assign coalesce     = accept && coalesce_hit;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        idx_d      = idx_q;
        btb_inv_en = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            IDLE, DRAIN: begin
                if (flush_req) begin
                    state_d  = SWEEP;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    idx_d    = '0;
                end else begin
                    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (push)
                        state_d = DRAIN;
                    else if (pop && one_left)
                        state_d = IDLE;
                end
            end
            SWEEP: begin
                if (!btb_busy) begin
                    btb_inv_en = 1'b1;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == IDX_BITS'(BTB_SETS - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
        end
    end

    // Payload storage needs no reset: pointers define validity and outputs are gated.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_idx]    <= upd_pc;
            tgt_mem[wr_idx]   <= upd_target;
            taken_mem[wr_idx] <= upd_taken | upd_is_jal;
            jal_mem[wr_idx]   <= upd_is_jal;
        end else if (coalesce) begin
            tgt_mem[last_idx]   <= upd_target;
            taken_mem[last_idx] <= upd_taken | upd_is_jal;
            jal_mem[last_idx]   <= upd_is_jal;
        end
    end

    assign btb_wr_en     = pop;
    assign btb_wr_pc     = pop ? pc_mem[rd_idx]    : '0;
    assign btb_wr_target = pop ? tgt_mem[rd_idx]   : '0;
    assign btb_wr_taken  = pop ? taken_mem[rd_idx] : 1'b0;
    assign btb_wr_jal    = pop ? jal_mem[rd_idx]   : 1'b0;
    assign btb_inv_idx   = btb_inv_en ? idx_q : '0;
    assign flush_busy    = (state_q == SWEEP) || (state_q == DONE);
    assign occupancy     = occ;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_btb_update_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int BTB_SETS   = 32;
    localparam int IDX_BITS   = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid, upd_ready, upd_taken, upd_is_jal;
    logic [31:0] upd_pc, upd_target;
    logic        flush_req, flush_busy, flush_done, btb_busy;
    logic        btb_wr_en, btb_wr_taken, btb_wr_jal, btb_inv_en;
    logic [31:0] btb_wr_pc, btb_wr_target;
    logic [IDX_BITS-1:0] btb_inv_idx;
    logic [$clog2(FIFO_DEPTH):0] occupancy;

    always #5 clk = ~clk;

    btb_update_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .BTB_SETS(BTB_SETS), .IDX_BITS(IDX_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_is_jal(upd_is_jal),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .btb_busy(btb_busy), .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc),
        .btb_wr_target(btb_wr_target), .btb_wr_taken(btb_wr_taken), .btb_wr_jal(btb_wr_jal),
        .btb_inv_en(btb_inv_en), .btb_inv_idx(btb_inv_idx), .occupancy(occupancy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        jal;
    } entry_t;

    entry_t modelQ[$];
    bit     modelSweep, modelDone;
    int     modelIdx;
    int     assertCount = 0;
    int     failCount   = 0;

    bit     planValid, planAccept, planCoal, planPop, planFlush, planBusy;
    entry_t planEntry, headEntry;
    bit     inService, expWrEn, expCoal, expReady, expInv;
    int     occNow;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: compare on the falling edge, advance on the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                modelQ.delete();
                modelSweep = 0;
                modelDone  = 0;
                modelIdx   = 0;
            end
            inService = !modelSweep && !modelDone;
            occNow    = modelQ.size();
            expWrEn   = inService && occNow > 0 && !btb_busy && !flush_req;
            expCoal   = 0;
            if (occNow > 0)
                expCoal = (upd_pc == modelQ[occNow-1].pc) && !(expWrEn && occNow == 1);
            expReady  = inService && !flush_req && (occNow < FIFO_DEPTH || expCoal);
            expInv    = modelSweep && !btb_busy;
            headEntry = '{32'h0, 32'h0, 1'b0, 1'b0};
            if (expWrEn) headEntry = modelQ[0];

            checkOutput("cmp_upd_ready",     32'(upd_ready),     32'(expReady));
            checkOutput("cmp_btb_wr_en",     32'(btb_wr_en),     32'(expWrEn));
            checkOutput("cmp_btb_wr_pc",     btb_wr_pc,          headEntry.pc);
            checkOutput("cmp_btb_wr_target", btb_wr_target,      headEntry.tgt);
            checkOutput("cmp_btb_wr_taken",  32'(btb_wr_taken),  32'(headEntry.taken));
            checkOutput("cmp_btb_wr_jal",    32'(btb_wr_jal),    32'(headEntry.jal));
            checkOutput("cmp_btb_inv_en",    32'(btb_inv_en),    32'(expInv));
            checkOutput("cmp_btb_inv_idx",   32'(btb_inv_idx),   expInv ? 32'(modelIdx) : 32'h0);
            checkOutput("cmp_flush_busy",    32'(flush_busy),    32'(modelSweep || modelDone));
            checkOutput("cmp_flush_done",    32'(flush_done),    32'(modelDone));
            checkOutput("cmp_occupancy",     32'(occupancy),     32'(occNow));

            planValid  = rst_n;
            planAccept = upd_valid && expReady;
            planCoal   = expCoal;
            planPop    = expWrEn;
            planFlush  = inService && flush_req;
            planBusy   = btb_busy;
            planEntry  = '{upd_pc, upd_target, upd_taken | upd_is_jal, upd_is_jal};

            @(posedge clk);
            if (rst_n && planValid) begin
                if (modelSweep) begin
                    if (!planBusy) begin
                        if (modelIdx == BTB_SETS - 1) begin
                            modelSweep = 0;
                            modelDone  = 1;
                            modelIdx   = 0;
                        end else begin
                            modelIdx++;
                        end
                    end
                end else if (modelDone) begin
                    modelDone = 0;
                end else if (planFlush) begin
                    modelQ.delete();
                    modelSweep = 1;
                    modelIdx   = 0;
                end else begin
                    if (planAccept && planCoal) begin
                        modelQ[modelQ.size()-1].tgt   = planEntry.tgt;
                        modelQ[modelQ.size()-1].taken = planEntry.taken;
                        modelQ[modelQ.size()-1].jal   = planEntry.jal;
                    end
                    if (planPop) void'(modelQ.pop_front());
                    if (planAccept && !planCoal) modelQ.push_back(planEntry);
                end
            end
        end
    end

    // Drive for one clock, then drop the one-shot inputs so checks see a quiet bus.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic tk, input logic jal, input logic busy, input logic fl);
        upd_valid  = v;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        upd_is_jal = jal;
        btb_busy   = busy;
        flush_req  = fl;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush_req = 1'b0;
        #1;
    endtask

    task automatic runSweep(input bit toggleBusy);
        int  k = 0;
        int  expIdx = 0;
        int  busyCycles = 0;
        bit  seen = 0;
        checkOutput("sweepBusyHigh", 32'(flush_busy), 32'h1);
        while (!seen && k < 200) begin
            k++;
            checkOutput("sweepNoWrite", 32'(btb_wr_en), 32'h0);
            if (flush_busy && !flush_done && btb_busy) busyCycles++;
            if (btb_inv_en) begin
                checkOutput("sweepIdx", 32'(btb_inv_idx), 32'(expIdx));
                expIdx++;
            end
            if (flush_done)
                seen = 1;
            else
                applyStimulus(0, 0, 0, 0, 0, toggleBusy ? 1'($urandom_range(0, 1)) : 1'b0, 0);
        end
        checkOutput("sweepDoneSeen", 32'(seen), 32'h1);
        checkOutput("sweepCycles", 32'(k), 32'(33 + busyCycles));
        checkOutput("sweepIdxCount", 32'(expIdx), 32'd32);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("sweepIdleBusy", 32'(flush_busy), 32'h0);
        checkOutput("sweepIdleReady", 32'(upd_ready), 32'h1);
        checkOutput("sweepIdleOcc", 32'(occupancy), 32'h0);
    endtask

    initial begin
        bit found;
        bit lastFlush;
        rst_n = 1'b0;
        upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; upd_is_jal = 0;
        flush_req = 0; btb_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetReady", 32'(upd_ready), 32'h1);
        checkOutput("resetWrEn", 32'(btb_wr_en), 32'h0);
        checkOutput("resetOcc", 32'(occupancy), 32'h0);
        checkOutput("resetFlushBusy", 32'(flush_busy), 32'h0);
        checkOutput("resetInvEn", 32'(btb_inv_en), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single update drains one cycle after acceptance.
        applyStimulus(1, 32'h100, 32'h200, 1, 0, 0, 0);
        checkOutput("singleOcc", 32'(occupancy), 32'h1);
        checkOutput("singleWrEn", 32'(btb_wr_en), 32'h1);
        checkOutput("singleWrPc", btb_wr_pc, 32'h100);
        checkOutput("singleWrTgt", btb_wr_target, 32'h200);
        checkOutput("singleWrTaken", 32'(btb_wr_taken), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("singleOccAfter", 32'(occupancy), 32'h0);
        checkOutput("singleWrEnAfter", 32'(btb_wr_en), 32'h0);

        // Fill with the BTB stalled, then probe full and coalesce-when-full.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 32'h1000 + 32'(i * 16), 32'h5000 + 32'(i), 1, 0, 1, 0);
        checkOutput("fullOcc", 32'(occupancy), 32'h4);
        upd_valid = 1; upd_pc = 32'h1040; upd_target = 32'h7000;
        #1;
        checkOutput("fullReady", 32'(upd_ready), 32'h0);
        upd_pc = 32'h1030;
        #1;
        checkOutput("coalesceFullReady", 32'(upd_ready), 32'h1);
        applyStimulus(1, 32'h1030, 32'h6000, 1, 0, 1, 0);
        checkOutput("coalesceFullOcc", 32'(occupancy), 32'h4);
        for (int i = 0; i < 4; i++) begin
            btb_busy = 0;
            #1;
            checkOutput("drainPc", btb_wr_pc, 32'h1000 + 32'(i * 16));
            if (i == 3) checkOutput("drainCoalescedTgt", btb_wr_target, 32'h6000);
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("drainOcc", 32'(occupancy), 32'h0);

        // Back-to-back same PC collapses into one entry carrying the later fields.
        applyStimulus(1, 32'h40, 32'h80, 1, 0, 1, 0);
        applyStimulus(1, 32'h40, 32'h84, 0, 0, 1, 0);
        checkOutput("pairOcc", 32'(occupancy), 32'h1);
        btb_busy = 0;
        #1;
        checkOutput("pairWrEn", 32'(btb_wr_en), 32'h1);
        checkOutput("pairWrTaken", 32'(btb_wr_taken), 32'h0);
        checkOutput("pairWrTgt", btb_wr_target, 32'h84);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pairOccAfter", 32'(occupancy), 32'h0);

        // Flush discards queued work and sweeps every set.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 32'h3000 + 32'(i * 8), 32'h9000, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        runSweep(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        runSweep(1);

        // Reset during a sweep returns to idle with no completion pulse.
        applyStimulus(1, 32'h4000, 32'h4100, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (btb_inv_en && btb_inv_idx == 5'd10) found = 1;
            else applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("midSweepFound", 32'(found), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetInvEn", 32'(btb_inv_en), 32'h0);
        checkOutput("midResetBusy", 32'(flush_busy), 32'h0);
        checkOutput("midResetReady", 32'(upd_ready), 32'h1);
        checkOutput("midResetOcc", 32'(occupancy), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midResetNoDone", 32'(flush_done), 32'h0);
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("postResetReady", 32'(upd_ready), 32'h1);
        checkOutput("postResetNoDone", 32'(flush_done), 32'h0);

        // Randomized traffic over a small PC pool to provoke coalescing.
        lastFlush = 0;
        for (int i = 0; i < 3000; i++) begin
            logic jal, fl;
            jal = ($urandom_range(0, 3) == 0);
            fl  = !lastFlush && ($urandom_range(0, 79) == 0);
            lastFlush = fl;
            applyStimulus($urandom_range(0, 2) != 0,
                          32'h2000 + 32'($urandom_range(0, 5) << 3),
                          $urandom,
                          jal ? 1'b1 : 1'($urandom_range(0, 1)),
                          jal,
                          $urandom_range(0, 2) == 0,
                          fl);
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
